// File: rtl/alu_definitions.sv
// ALU operation codes shared with the ALU control decoder, plus the flag bundle
// that travels with every result.
package alu_definitions;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal_operation;
  } alu_flags_t;

endpackage

// File: rtl/arithmetic_logic_unit_core.sv
// Combinational ALU datapath: result and flags from code and operands.
module arithmetic_logic_unit_core
  import alu_definitions::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_control_signal,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic [WIDTH-1:0] sum, diff;
  logic add_ovf, sub_ovf;

  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;
  assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1]  != operand_a[WIDTH-1]);
  assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);

  always_comb begin
    result = '0;
    flags  = '0;
    unique case (alu_control_signal)
      ALU_AND: result = operand_a & operand_b;
      ALU_OR:  result = operand_a | operand_b;
      ALU_XOR: result = operand_a ^ operand_b;
      ALU_NOR: result = ~(operand_a | operand_b);
      ALU_ADD: begin result = sum;  flags.overflow = add_ovf; end
      ALU_SUB: begin result = diff; flags.overflow = sub_ovf; end
      // sign of the difference corrected by overflow stays right at the extremes
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      default: flags.illegal_operation = 1'b1;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/arithmetic_logic_unit_execute.sv
// Execute-stage ALU with a 2-entry output FIFO; in_ready depends only on the
// registered occupancy so a downstream stall never reaches decode combinationally.
module arithmetic_logic_unit_execute
  import alu_definitions::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           alu_control_signal,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 illegal_operation,
  output logic [TAG_WIDTH-1:0] out_tag
);

  typedef struct packed {
    logic [WIDTH-1:0]     result;
    alu_flags_t           flags;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t     fifo_q [2];
  entry_t     in_entry, head;
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       accept, pop;

  arithmetic_logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .alu_control_signal (alu_control_signal),
    .operand_a          (operand_a),
    .operand_b          (operand_b),
    .result             (in_entry.result),
    .flags              (in_entry.flags)
  );
  assign in_entry.tag = in_tag;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        fifo_q[wr_ptr] <= in_entry;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, pop};
    end
  end

  // data outputs read as zero whenever nothing is presented
  assign head              = out_valid ? fifo_q[rd_ptr] : '0;
  assign result            = head.result;
  assign zero              = head.flags.zero;
  assign overflow          = head.flags.overflow;
  assign illegal_operation = head.flags.illegal_operation;
  assign out_tag           = head.tag;

endmodule

// File: tb/tb_arithmetic_logic_unit_execute.sv
// Scoreboard bench: the driver pushes model results for accepted ops, the monitor
// checks handshakes and pops/compares each transfer at the falling edge.
module tb_arithmetic_logic_unit_execute;

  localparam int W  = 32;
  localparam int TW = 5;

  typedef struct {
    logic [W-1:0]  res;
    logic          z, ov, ill;
    logic [TW-1:0] tag;
  } exp_t;

  logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, zero, overflow, illegal_operation;
  logic [3:0]    alu_control_signal = '0;
  logic [W-1:0]  operand_a = '0, operand_b = '0, result;
  logic [TW-1:0] in_tag = '0, out_tag;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  logic last_acc;

  always #5 clock = ~clock;

  arithmetic_logic_unit_execute #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control_signal(alu_control_signal),
    .operand_a(operand_a), .operand_b(operand_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal_operation(illegal_operation),
    .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference built from signed integer arithmetic rather than bit tricks.
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] t);
    exp_t e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.ov = 1'b0; e.ill = 1'b0; e.tag = t;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1101: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin r = sa + sb; e.res = r[W-1:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0110: begin r = sa - sb; e.res = r[W-1:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // One cycle: inputs already set at posedge+1; decide accept at the falling edge.
  task automatic step();
    logic acc, fl;
    @(negedge clock);
    acc = in_valid && in_ready && !flush;
    fl  = flush;
    @(posedge clock);
    if (fl) q.delete();
    else if (acc) q.push_back(model(alu_control_signal, operand_a, operand_b, in_tag));
    last_acc = acc;
    #1;
  endtask

  task automatic op(input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [TW-1:0] t, input logic rdy);
    in_valid = v; alu_control_signal = c; operand_a = a; operand_b = b; in_tag = t; out_ready = rdy;
    step();
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (out_valid && q.size() > 0) begin
          e = q[0];
          chk("result", result, e.res);
          chk("zero", zero, e.z);
          chk("overflow", overflow, e.ov);
          chk("illegal", illegal_operation, e.ill);
          chk("tag", out_tag, e.tag);
          if (out_ready && !flush) void'(q.pop_front());
        end else if (!out_valid) begin
          chk("idle_data", {result, zero, overflow, illegal_operation, out_tag}, '0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'(int'($urandom_range(0, 7)));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [3:0] codes [8];
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
    codes[4] = 4'b0111; codes[5] = 4'b1100; codes[6] = 4'b1101; codes[7] = 4'b1111;

    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data", {result, zero, overflow, illegal_operation, out_tag}, '0);
    @(posedge clock); #1; reset = 1'b0;

    // directed
    op(1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd9, 1);
    chk("add_valid", out_valid, 1'b1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_ovf", overflow, 1'b1);
    chk("add_zero", zero, 1'b0);
    op(1, 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd1, 1);
    chk("slt_res", result, 32'd1);
    op(1, 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd2, 1);
    chk("slt_swap_res", result, 32'd0);
    chk("slt_swap_ovf", overflow, 1'b0);
    op(1, 4'b0110, 32'd5, 32'd5, 5'd3, 1);
    chk("sub_zero", zero, 1'b1);
    op(1, 4'b1111, 32'd12, 32'd34, 5'd4, 1);
    chk("ill_flag", illegal_operation, 1'b1);
    chk("ill_res", result, 32'd0);
    op(0, 4'b0000, 0, 0, 0, 1);

    // backpressure: three ops with out_ready low
    op(1, 4'b0001, 32'h10, 32'h01, 5'd1, 0);
    op(1, 4'b0001, 32'h20, 32'h02, 5'd2, 0);
    chk("full_in_ready", in_ready, 1'b0);
    op(1, 4'b0001, 32'h30, 32'h03, 5'd3, 0);
    chk("op3_blocked", last_acc, 1'b0);
    op(1, 4'b0001, 32'h30, 32'h03, 5'd3, 1);
    chk("op3_blocked_pop", last_acc, 1'b0);
    chk("ready_after_pop", in_ready, 1'b1);
    begin
      int k = 0;
      do begin op(1, 4'b0001, 32'h30, 32'h03, 5'd3, 1); k++; end while (!last_acc && k < 10);
      chk("op3_accepted", last_acc, 1'b1);
    end
    op(0, 0, 0, 0, 0, 1);
    op(0, 0, 0, 0, 0, 1);

    // flush with full buffer and an incoming op
    op(1, 4'b0010, 32'd1, 32'd1, 5'd5, 0);
    op(1, 4'b0010, 32'd2, 32'd2, 5'd6, 0);
    flush = 1'b1;
    op(1, 4'b0010, 32'd3, 32'd3, 5'd7, 0);
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    op(0, 0, 0, 0, 0, 1);
    chk("flush_absent", out_valid, 1'b0);

    // asynchronous reset mid-cycle with one entry buffered
    op(1, 4'b1101, 32'hF0F0, 32'h0FF0, 5'd8, 0);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2; reset = 1'b1; #1;
    q.delete();
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_data", {result, zero, overflow, illegal_operation, out_tag}, '0);
    @(posedge clock); #1; reset = 1'b0;
    op(0, 0, 0, 0, 0, 1);
    chk("post_rst_empty", out_valid, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 29) == 0);
      op($urandom_range(0, 3) != 0, codes[$urandom_range(0, 7)], rand_operand(), rand_operand(),
         TW'($urandom()), $urandom_range(0, 2) != 0);
    end
    flush = 1'b0;
    for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 0, 1);
    chk("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
